bus_xfer_sequencer: RTL

//  Load side of the 32-bit datapath bus: sequences single register-transfer micro-ops
//  (src -> bus -> dst). Turns an encoded transfer request into one-hot bus-mux out-selects

---
 rtl/bus_xfer_sequencer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/bus_xfer_sequencer.sv
// -----------------------------------------------------------------------------
// bus_xfer_sequencer
//
// Purpose:
//   Load side of the 32-bit datapath bus. Sequences one register-transfer
//   micro-op at a time (src -> bus -> dst). It turns an encoded request into a
//   one-hot bus-mux out-select and a one-hot destination load enable, both
//   asserted together for a single DRIVE cycle. When the source is MDR it can
//   first fetch MDR from memory through a read handshake with a timeout.
//
// Ports:
//   clock       in   1   system clock, rising edge
//   clear       in   1   asynchronous active-high reset
//   req_valid   in   1   transfer request valid
//   req_ready   out  1   request can be accepted (IDLE only)
//   req_src     in   5   source code (0-15 R0-R15, 16 HI, 17 LO, 18 Zhigh,
//                        19 Zlow, 20 PC, 21 MDR, 22 InPort, 23 C)
//   req_dst     in   5   dest code (0-15 R0-R15, 16 HI, 17 LO, 18 PC, 19 MDR,
//                        20 MAR, 21 IR, 22 Y, 23 OutPort)
//   req_mem_rd  in   1   fill MDR from memory before driving (src must be 21)
//   src_sel     out  24  one-hot bus-mux out-select
//   dst_ld      out  24  one-hot destination load enable
//   mem_read    out  1   memory read strobe, high for every MEM_WAIT cycle
//   mdr_ld_mem  out  1   one-cycle MDR load-from-memory strobe
//   mem_done    in   1   memory read data valid
//   xfer_done   out  1   one-cycle pulse, transfer completed
//   xfer_err    out  1   one-cycle pulse, request rejected or timed out
// -----------------------------------------------------------------------------
module bus_xfer_sequencer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_src,
  input  logic [4:0]  req_dst,
  input  logic        req_mem_rd,
  output logic [23:0] src_sel,
  output logic [23:0] dst_ld,
  output logic        mem_read,
  output logic        mdr_ld_mem,
  input  logic        mem_done,
  output logic        xfer_done,
  output logic        xfer_err
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] DRIVE    = 2'd2;
  localparam logic [1:0] DONE     = 2'd3;

  // The counter only has to reach MEM_TIMEOUT-1.
  localparam int              CW   = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CW-1:0]   LAST = CW'(MEM_TIMEOUT - 1);

  logic [1:0]    r_state;
  logic [4:0]    r_src;
  logic [4:0]    r_dst;
  logic [CW-1:0] r_count;
  logic          r_mdrPending;

  logic w_accept;
  logic w_illegal;

  // Requests are taken only in IDLE; anything presented elsewhere is ignored.
  assign req_ready = (r_state == IDLE);
  assign w_accept  = req_valid && req_ready;

  // Codes above 23 do not exist, and a memory fill only makes sense for MDR.
  assign w_illegal = (req_src > 5'd23) || (req_dst > 5'd23) ||
                     (req_mem_rd && (req_src != 5'd21));

  // Single registered sequencer. The pulse-style outputs default to zero every
  // cycle, so each state only raises what it needs for the following cycle.
  // The memory path spends an extra DRIVE cycle (r_mdrPending) so that MDR
  // captures memory data before it is ever placed on the bus.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state      <= IDLE;
      r_src        <= 5'd0;
      r_dst        <= 5'd0;
      r_count      <= '0;
      r_mdrPending <= 1'b0;
      src_sel      <= 24'd0;
      dst_ld       <= 24'd0;
      mem_read     <= 1'b0;
      mdr_ld_mem   <= 1'b0;
      xfer_done    <= 1'b0;
      xfer_err     <= 1'b0;
    end else begin
      src_sel    <= 24'd0;
      dst_ld     <= 24'd0;
      mdr_ld_mem <= 1'b0;
      xfer_done  <= 1'b0;
      xfer_err   <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_illegal) begin
              xfer_err <= 1'b1;
            end else begin
              r_src <= req_src;
              r_dst <= req_dst;
              if (req_mem_rd) begin
                r_state  <= MEM_WAIT;
                r_count  <= '0;
                mem_read <= 1'b1;
              end else begin
                r_state <= DRIVE;
                src_sel <= 24'd1 << req_src;
                dst_ld  <= 24'd1 << req_dst;
              end
            end
          end
        end

        MEM_WAIT: begin
          // mem_done takes priority over a timeout in the same cycle.
          if (mem_done) begin
            mem_read     <= 1'b0;
            mdr_ld_mem   <= 1'b1;
            r_mdrPending <= 1'b1;
            r_state      <= DRIVE;
          end else if (r_count == LAST) begin
            mem_read <= 1'b0;
            xfer_err <= 1'b1;
            r_state  <= IDLE;
          end else begin
            r_count <= r_count + CW'(1);
          end
        end

        DRIVE: begin
          if (r_mdrPending) begin
            r_mdrPending <= 1'b0;
            src_sel      <= 24'd1 << r_src;
            dst_ld       <= 24'd1 << r_dst;
          end else begin
            xfer_done <= 1'b1;
            r_state   <= DONE;
          end
        end

        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
